// File: rtl/seq_bin2bcd_converter_if.sv
// Handshake and result bundle for seq_bin2bcd_converter.
// The master side drives start and data. The slave side returns the status and the BCD result.
interface seq_bin2bcd_converter_if #(
    parameter int INPUT_BIT_WIDTH     = 8,
    parameter int OUTPUT_DIGITS_COUNT = 3
);
    logic                               start_i;
    logic [INPUT_BIT_WIDTH-1:0]         data_i;
    logic                               busy_o;
    logic                               done_o;
    logic [4*OUTPUT_DIGITS_COUNT-1:0]   bcd_o;
    logic                               negative_o;
    logic                               overflow_o;

    modport master (
        output start_i, data_i,
        input  busy_o, done_o, bcd_o, negative_o, overflow_o
    );

    modport slave (
        input  start_i, data_i,
        output busy_o, done_o, bcd_o, negative_o, overflow_o
    );
endinterface

// File: rtl/seq_bin2bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter that processes one input bit per clock.
// It has a signed-magnitude mode and a sticky overflow flag for values too wide for the digit count.
module seq_bin2bcd_converter #(
    parameter int INPUT_BIT_WIDTH     = 8,
    parameter int OUTPUT_DIGITS_COUNT = 3,
    parameter int SIGNED_MODE         = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    seq_bin2bcd_converter_if.slave bus
);
    localparam int W  = INPUT_BIT_WIDTH;
    localparam int D  = OUTPUT_DIGITS_COUNT;
    localparam int BW = 4 * D;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    shift_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   out_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            sign_q;
    logic            neg_q;
    logic            ovf_q;
    logic            done_q;

    logic            start_ok;
    logic            last_shift;
    logic            in_neg;
    logic [W-1:0]    mag;
    logic [BW-1:0]   bcd_adj;
    logic            busy;

    assign start_ok   = (state_q == S_IDLE) && bus.start_i;
    assign last_shift = (cnt_q == CW'(W - 1));

    // The most negative input negates to itself. Read as unsigned, that is exactly 2**(W-1).
    assign in_neg = (SIGNED_MODE != 0) && bus.data_i[W-1];
    assign mag    = in_neg ? -bus.data_i : bus.data_i;

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                   : bcd_q[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_SHIFT;
            S_SHIFT:  if (last_shift) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state_q != S_IDLE) busy = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            bcd_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        shift_q <= mag;
                        sign_q  <= in_neg;
                        bcd_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_SHIFT: begin
                    // A bit shifted out of the top digit means the value is at least 10**D.
                    bcd_q   <= {bcd_adj[BW-2:0], shift_q[W-1]};
                    shift_q <= {shift_q[W-2:0], 1'b0};
                    carry_q <= carry_q | bcd_adj[BW-1];
                    cnt_q   <= cnt_q + 1'b1;
                end
                S_FINISH: begin
                    out_q  <= bcd_q;
                    neg_q  <= sign_q;
                    ovf_q  <= carry_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o     = busy;
    assign bus.done_o     = done_q;
    assign bus.bcd_o      = out_q;
    assign bus.negative_o = neg_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_seq_bin2bcd_converter.sv
// Scoreboard bench: three converter variants (3-digit unsigned, 2-digit unsigned, 3-digit signed)
// receive the same input stream. Each result is compared against an arithmetic reference model.
module tb_seq_bin2bcd_converter;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data;

    int checks   = 0;
    int failures = 0;

    logic [13:0] q0[$];
    logic [13:0] q1[$];
    logic [13:0] q2[$];

    seq_bin2bcd_converter_if #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(3)) if0 ();
    seq_bin2bcd_converter_if #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(2)) if1 ();
    seq_bin2bcd_converter_if #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(3)) if2 ();

    assign if0.start_i = start;
    assign if1.start_i = start;
    assign if2.start_i = start;
    assign if0.data_i  = data;
    assign if1.data_i  = data;
    assign if2.data_i  = data;

    seq_bin2bcd_converter #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(3), .SIGNED_MODE(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0.slave)
    );
    seq_bin2bcd_converter #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(2), .SIGNED_MODE(0)) u_dut_d2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1.slave)
    );
    seq_bin2bcd_converter #(.INPUT_BIT_WIDTH(8), .OUTPUT_DIGITS_COUNT(3), .SIGNED_MODE(1)) u_dut_s (
        .clk_i(clk), .rst_ni(rst_n), .bus(if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {negative, overflow, 12-bit BCD}.
    function automatic logic [13:0] model(input logic [7:0] x, input int d, input bit sgn);
        int         m;
        int         lim;
        int         v;
        bit         neg;
        logic [11:0] b;
        neg = sgn && x[7];
        m   = neg ? 256 - int'(x) : int'(x);
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        v = m % lim;
        b = '0;
        for (int i = 0; i < d; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {neg, (m >= lim), b};
    endfunction

    always @(negedge clk) begin
        if (if0.done_o) begin
            if (q0.size() == 0) check("unexpected_done_d3", 1, 0);
            else begin
                check("result_d3", {if0.negative_o, if0.overflow_o, if0.bcd_o}, q0.pop_front());
                check("busy_in_done_d3", if0.busy_o, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (if1.done_o) begin
            if (q1.size() == 0) check("unexpected_done_d2", 1, 0);
            else check("result_d2", {if1.negative_o, if1.overflow_o, 4'h0, if1.bcd_o}, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (if2.done_o) begin
            if (q2.size() == 0) check("unexpected_done_signed", 1, 0);
            else check("result_signed", {if2.negative_o, if2.overflow_o, if2.bcd_o}, q2.pop_front());
        end
    end

    // Starts a conversion of x and returns on the negedge where Done is seen.
    // If hold is set, Start stays high with random data for several cycles of the conversion.
    task automatic convert(input logic [7:0] x, input bit hold);
        int lat;
        int busy_cnt;
        start = 1'b1;
        data  = x;
        q0.push_back(model(x, 3, 1'b0));
        q1.push_back(model(x, 2, 1'b0));
        q2.push_back(model(x, 3, 1'b1));
        @(negedge clk);
        lat      = 0;
        busy_cnt = 0;
        while (!if0.done_o && lat < 20) begin
            if (if0.busy_o) busy_cnt++;
            lat++;
            if (hold && lat < 6) begin
                start = 1'b1;
                data  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("latency", lat, 9);
        check("busy_cycles", busy_cnt, 9);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        start = 1'b0;
        data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", if0.bcd_o, 0);
        check("rst_busy", if0.busy_o, 0);
        check("rst_done", if0.done_o, 0);
        check("rst_flags", {if0.negative_o, if0.overflow_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(8'd255, 1'b0);
        convert(8'd0, 1'b0);
        convert(8'd9, 1'b0);
        convert(8'd100, 1'b0);
        convert(8'd123, 1'b0);
        convert(8'd99, 1'b0);
        convert(8'h80, 1'b0);
        convert(8'hFF, 1'b0);
        convert(8'h7F, 1'b0);
        convert(8'd77, 1'b1);
        convert(8'd200, 1'b1);

        repeat (3) @(negedge clk);
        check("hold_bcd", if0.bcd_o, 12'h200);
        check("hold_signed_neg", if2.negative_o, 1);

        // Abort a conversion partway through the shift phase.
        start = 1'b1;
        data  = 8'd150;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd", if0.bcd_o, 0);
        check("abort_busy", if0.busy_o, 0);
        check("abort_flags_signed", {if2.negative_o, if2.overflow_o, if2.bcd_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (if0.done_o) seen++;
        end
        check("no_done_after_abort", seen, 0);
        convert(8'd42, 1'b0);

        for (int i = 0; i < 256; i++) convert(8'(i), 1'b0);

        repeat (2) @(negedge clk);
        check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
